uart_echo_core: RTL and testbench

- Parametrised, self-contained UART core: 16x-oversampling baud tick, receiver, transmitter and a configurable-depth TX FIFO in one block.
- Successor to the fixed 8-bit / fixed-depth UART top.
- Adds runtime echo/host mode selection, host write handshake, frame-error detection, overflow flag and FIFO level reporting.
- Sits directly on the board RX/TX pins (e.g. HC-06 Bluetooth link).

---
 rtl/uart_echo_core.sv | 359 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_echo_core.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_core.sv
// uart_echo_core: 16x-oversampled UART (baud tick, RX, TX, TX FIFO) with
// runtime echo/host source selection, frame-error, overflow and level reporting.
// Optional feature macro: PARITY_EN adds an even-parity bit to every frame
// on both directions and a ParityErr pulse output.
module uart_echo_core #(
    parameter int unsigned BAUD_DIV  = 325,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Rx,
    output logic                 Tx,
    input  logic                 EchoEn,
    input  logic [DATA_BITS-1:0] TxData,
    input  logic                 TxValid,
    output logic                 TxReady,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxDone,
    output logic                 FrameErr,
`ifdef PARITY_EN
    output logic                 ParityErr,
`endif
    output logic                 TxDone,
    output logic                 TxBusy,
    output logic                 Overflow,
    input  logic                 OvfClr,
    output logic [FIFO_AW:0]     Level
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned LVL_W = FIFO_AW + 1;
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned BIT_W = 4;
    localparam int unsigned OS_W  = 4;

    localparam logic [OS_W-1:0]  OS_MID  = OS_W'(7);
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(15);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rxState_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } txState_t;

    // ------------------------------------------------------------------
    // Oversample tick
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] baudCnt;
    logic             baudTick;

    assign baudTick = (baudCnt == CNT_W'(BAUD_DIV - 1));

    // Free-running divider, one tick every BAUD_DIV clocks.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            baudCnt <= '0;
        end else if (baudTick) begin
            baudCnt <= '0;
        end else begin
            baudCnt <= baudCnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic rxMeta;
    logic rxSync;

    // Two-flop synchroniser for the asynchronous serial input (idle high).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= Rx;
            rxSync <= rxMeta;
        end
    end

    rxState_t             rxState;
    logic [OS_W-1:0]      rxTicks;
    logic [BIT_W-1:0]     rxBits;
    logic [DATA_BITS-1:0] rxShift;
`ifdef PARITY_EN
    logic                 rxParBit;
`endif

    // Receiver: mid-bit sampling driven by the oversample tick.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rxState   <= RX_IDLE;
            rxTicks   <= '0;
            rxBits    <= '0;
            rxShift   <= '0;
            RxData    <= '0;
            RxDone    <= 1'b0;
            FrameErr  <= 1'b0;
`ifdef PARITY_EN
            rxParBit  <= 1'b0;
            ParityErr <= 1'b0;
`endif
        end else begin
            RxDone    <= 1'b0;
            FrameErr  <= 1'b0;
`ifdef PARITY_EN
            ParityErr <= 1'b0;
`endif
            if (baudTick) begin
                case (rxState)
                    RX_IDLE: begin
                        if (!rxSync) begin
                            rxState <= RX_START;
                            rxTicks <= '0;
                        end
                    end
                    RX_START: begin
                        if (rxTicks == OS_MID) begin
                            rxTicks <= '0;
                            rxBits  <= '0;
                            rxState <= rxSync ? RX_IDLE : RX_DATA;
                        end else begin
                            rxTicks <= rxTicks + OS_W'(1);
                        end
                    end
                    RX_DATA: begin
                        if (rxTicks == OS_LAST) begin
                            rxTicks <= '0;
                            rxShift <= {rxSync, rxShift[DATA_BITS-1:1]};
                            rxBits  <= rxBits + BIT_W'(1);
                            if (rxBits == LAST_BIT) begin
`ifdef PARITY_EN
                                rxState <= RX_PAR;
`else
                                rxState <= RX_STOP;
`endif
                            end
                        end else begin
                            rxTicks <= rxTicks + OS_W'(1);
                        end
                    end
`ifdef PARITY_EN
                    RX_PAR: begin
                        if (rxTicks == OS_LAST) begin
                            rxTicks  <= '0;
                            rxParBit <= rxSync;
                            rxState  <= RX_STOP;
                        end else begin
                            rxTicks <= rxTicks + OS_W'(1);
                        end
                    end
`endif
                    RX_STOP: begin
                        if (rxTicks == OS_LAST) begin
                            rxTicks <= '0;
                            rxState <= RX_IDLE;
                            if (!rxSync) begin
                                FrameErr <= 1'b1;
`ifdef PARITY_EN
                            end else if (rxParBit != (^rxShift)) begin
                                ParityErr <= 1'b1;
`endif
                            end else begin
                                RxData <= rxShift;
                                RxDone <= 1'b1;
                            end
                        end else begin
                            rxTicks <= rxTicks + OS_W'(1);
                        end
                    end
                    default: begin
                        rxState <= RX_IDLE;
                        rxTicks <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifoMem [DEPTH];
    logic [LVL_W-1:0]     wrPtr;
    logic [LVL_W-1:0]     rdPtr;
    logic                 fifoFull;
    logic                 wrReq;
    logic                 wrEn;
    logic                 popEn;
    logic [DATA_BITS-1:0] wrData;
    txState_t             txState;

    assign Level    = wrPtr - rdPtr;
    assign fifoFull = (Level == LVL_W'(DEPTH));
    assign TxReady  = !EchoEn && !fifoFull;

    // Source select: received bytes in echo mode, host handshake otherwise.
    assign wrReq  = EchoEn ? RxDone : (TxValid && TxReady);
    assign wrData = EchoEn ? RxData : TxData;

    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign popEn = (txState == TX_IDLE) && (Level != '0);
    assign wrEn  = wrReq && (!fifoFull || popEn);

    // Storage array; no reset needed since occupancy is tracked by the pointers.
    always_ff @(posedge Clk) begin
        if (wrEn) begin
            fifoMem[wrPtr[FIFO_AW-1:0]] <= wrData;
        end
    end

    // Pointer and sticky overflow bookkeeping; clear beats set.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + LVL_W'(1);
            end
            if (popEn) begin
                rdPtr <= rdPtr + LVL_W'(1);
            end
            if (OvfClr) begin
                Overflow <= 1'b0;
            end else if (wrReq && fifoFull && !popEn) begin
                Overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [OS_W-1:0]      txTicks;
    logic [BIT_W-1:0]     txBits;
    logic [DATA_BITS-1:0] txShift;
`ifdef PARITY_EN
    logic                 txPar;
`endif

    // Transmitter: pops the FIFO head, aligns to a tick, then shifts LSB first.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            txState <= TX_IDLE;
            txTicks <= '0;
            txBits  <= '0;
            txShift <= '0;
            Tx      <= 1'b1;
            TxBusy  <= 1'b0;
            TxDone  <= 1'b0;
`ifdef PARITY_EN
            txPar   <= 1'b0;
`endif
        end else begin
            TxDone <= 1'b0;
            case (txState)
                TX_IDLE: begin
                    Tx <= 1'b1;
                    if (popEn) begin
                        txShift <= fifoMem[rdPtr[FIFO_AW-1:0]];
`ifdef PARITY_EN
                        txPar   <= ^fifoMem[rdPtr[FIFO_AW-1:0]];
`endif
                        TxBusy  <= 1'b1;
                        txState <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (baudTick) begin
                        Tx      <= 1'b0;
                        txTicks <= '0;
                        txState <= TX_START;
                    end
                end
                TX_START: begin
                    if (baudTick) begin
                        if (txTicks == OS_LAST) begin
                            txTicks <= '0;
                            txBits  <= '0;
                            Tx      <= txShift[0];
                            txShift <= txShift >> 1;
                            txState <= TX_DATA;
                        end else begin
                            txTicks <= txTicks + OS_W'(1);
                        end
                    end
                end
                TX_DATA: begin
                    if (baudTick) begin
                        if (txTicks == OS_LAST) begin
                            txTicks <= '0;
                            txBits  <= txBits + BIT_W'(1);
                            if (txBits == LAST_BIT) begin
`ifdef PARITY_EN
                                Tx      <= txPar;
                                txState <= TX_PAR;
`else
                                Tx      <= 1'b1;
                                txState <= TX_STOP;
`endif
                            end else begin
                                Tx      <= txShift[0];
                                txShift <= txShift >> 1;
                            end
                        end else begin
                            txTicks <= txTicks + OS_W'(1);
                        end
                    end
                end
`ifdef PARITY_EN
                TX_PAR: begin
                    if (baudTick) begin
                        if (txTicks == OS_LAST) begin
                            txTicks <= '0;
                            Tx      <= 1'b1;
                            txState <= TX_STOP;
                        end else begin
                            txTicks <= txTicks + OS_W'(1);
                        end
                    end
                end
`endif
                TX_STOP: begin
                    if (baudTick) begin
                        if (txTicks == OS_LAST) begin
                            txTicks <= '0;
                            TxDone  <= 1'b1;
                            TxBusy  <= 1'b0;
                            txState <= TX_IDLE;
                        end else begin
                            txTicks <= txTicks + OS_W'(1);
                        end
                    end
                end
                default: begin
                    Tx      <= 1'b1;
                    TxBusy  <= 1'b0;
                    txState <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_core.sv
// Directed bench for uart_echo_core: BAUD_DIV=4 (64 clocks/bit), 8 data bits, depth-4 FIFO.
module tb_uart_echo_core;

    localparam int BIT_CLK = 64;
`ifdef PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLK = BIT_CLK * FRAME_BITS;

    logic       Clk;
    logic       Rst_n;
    logic       Rx;
    logic       Tx;
    logic       EchoEn;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;
    logic [7:0] RxData;
    logic       RxDone;
    logic       FrameErr;
    logic       TxDone;
    logic       TxBusy;
    logic       Overflow;
    logic       OvfClr;
    logic [2:0] Level;
`ifdef PARITY_EN
    logic       ParityErr;
`endif

    uart_echo_core #(.BAUD_DIV(4), .DATA_BITS(8), .FIFO_AW(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Rx(Rx), .Tx(Tx), .EchoEn(EchoEn),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .RxData(RxData), .RxDone(RxDone), .FrameErr(FrameErr),
`ifdef PARITY_EN
        .ParityErr(ParityErr),
`endif
        .TxDone(TxDone), .TxBusy(TxBusy), .Overflow(Overflow),
        .OvfClr(OvfClr), .Level(Level)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rxDoneCnt = 0;
    int feCnt     = 0;
    int peCnt     = 0;
    int txDoneCnt = 0;
    int txLowCnt  = 0;
    int frameStart = 0;
    logic inFrame  = 1'b0;
    logic busyGap  = 1'b0;
    logic txPrev   = 1'b1;
    logic sawBlock = 1'b0;
    logic [2:0] levelAtBlock = '0;
    logic [7:0] txq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Drive one frame onto Rx, LSB first; optional stop-low and parity flip.
    task automatic sendRx(input logic [7:0] d, input logic stopBit, input logic parFlip);
        Rx = 1'b0;
        waitClk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            Rx = d[i];
            waitClk(BIT_CLK);
        end
`ifdef PARITY_EN
        Rx = (^d) ^ parFlip;
        waitClk(BIT_CLK);
`else
        if (parFlip) Rx = 1'b1;
`endif
        Rx = stopBit;
        waitClk(BIT_CLK);
        Rx = 1'b1;
    endtask

    // Host handshake write, bounded wait on TxReady.
    task automatic hostWrite(input logic [7:0] d);
        @(negedge Clk);
        TxData  = d;
        TxValid = 1'b1;
        for (int g = 0; g < 5000 && !TxReady; g++) begin
            if (!sawBlock) begin
                sawBlock     = 1'b1;
                levelAtBlock = Level;
            end
            @(negedge Clk);
        end
        check("hostWrite ready", 32'(TxReady), 32'd1);
        @(posedge Clk);
        #1;
        TxValid = 1'b0;
    endtask

    always @(posedge Clk) cyc++;

    // Pulse counters and per-frame length / busy monitor.
    always @(negedge Clk) begin
        if (RxDone)   rxDoneCnt++;
        if (FrameErr) feCnt++;
        if (TxDone)   txDoneCnt++;
        if (!Tx)      txLowCnt++;
`ifdef PARITY_EN
        if (ParityErr) peCnt++;
`endif
        if (!Rst_n) begin
            inFrame = 1'b0;
        end else begin
            if (txPrev && !Tx && !inFrame) begin
                frameStart = cyc;
                inFrame    = 1'b1;
                busyGap    = 1'b0;
            end
            if (inFrame && !TxDone && !TxBusy) busyGap = 1'b1;
            if (TxDone) begin
                check("tx frame length", 32'(cyc - frameStart), 32'(FRAME_CLK));
                check("tx busy span", {30'd0, busyGap, TxBusy}, 32'd0);
                inFrame = 1'b0;
            end
        end
        txPrev = Tx;
    end

    // Serial decoder on Tx: mid-bit sampling, pushes bytes with a good stop bit.
    initial begin
        logic [7:0] b;
        logic       p;
        forever begin
            @(negedge Clk);
            if (Rst_n && !Tx) begin
                repeat (BIT_CLK / 2) @(negedge Clk);
                if (!Tx) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT_CLK) @(negedge Clk);
                        b[i] = Tx;
                    end
                    p = ^b;
`ifdef PARITY_EN
                    repeat (BIT_CLK) @(negedge Clk);
                    p = Tx;
`endif
                    repeat (BIT_CLK) @(negedge Clk);
                    if (Tx && (p == ^b)) txq.push_back(b);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       echo;
        logic [7:0] data;
        logic       stopBit;
        logic [7:0] expRxData;
        int         expDone;
        int         expFe;
        int         expTx;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int d0, f0, t0;
        vecs[0] = '{1'b0, 8'h55, 1'b0, 8'h00, 0, 1, 0};
        vecs[1] = '{1'b1, 8'h5A, 1'b1, 8'h5A, 1, 0, 1};
        vecs[2] = '{1'b1, 8'hFF, 1'b1, 8'hFF, 1, 0, 1};
        vecs[3] = '{1'b1, 8'h00, 1'b1, 8'h00, 1, 0, 1};
        vecs[4] = '{1'b1, 8'h33, 1'b0, 8'h00, 0, 1, 0};
        vecs[5] = '{1'b0, 8'hA7, 1'b1, 8'hA7, 1, 0, 0};
        vecs[6] = '{1'b1, 8'h81, 1'b1, 8'h81, 1, 0, 1};

        Rst_n = 1'b0; Rx = 1'b1; EchoEn = 1'b0;
        TxData = '0; TxValid = 1'b0; OvfClr = 1'b0;

        // Reset state
        #22;
        check("reset Tx", 32'(Tx), 32'd1);
        check("reset TxBusy", 32'(TxBusy), 32'd0);
        check("reset Level", 32'(Level), 32'd0);
        check("reset RxData", 32'(RxData), 32'd0);
        check("reset pulses", {29'd0, RxDone, FrameErr, TxDone}, 32'd0);
        check("reset Overflow", 32'(Overflow), 32'd0);
        check("reset TxReady", 32'(TxReady), 32'd1);
        waitClk(2);
        Rst_n = 1'b1;
        waitClk(5);

        // Reset mid-TX frame: async return to idle, FIFO flushed
        hostWrite(8'h96);
        hostWrite(8'h3C);
        waitClk(100);
        check("pre-reset Tx low", 32'(Tx), 32'd0);
        check("pre-reset TxBusy", 32'(TxBusy), 32'd1);
        check("pre-reset Level", 32'(Level), 32'd1);
        Rst_n = 1'b0;
        #1;
        check("async reset Tx", 32'(Tx), 32'd1);
        check("async reset TxBusy", 32'(TxBusy), 32'd0);
        check("async reset Level", 32'(Level), 32'd0);
        waitClk(10);
        Rst_n = 1'b1;
        waitClk(800);
        txq.delete();
        hostWrite(8'hC3);
        waitClk(FRAME_CLK + 200);
        check("post-reset tx count", 32'(txq.size()), 32'd1);
        if (txq.size() > 0) check("post-reset tx byte", 32'(txq[0]), 32'hC3);

        // Table-driven receive / echo vectors
        for (int i = 0; i < 7; i++) begin
            EchoEn = vecs[i].echo;
            waitClk(4);
            d0 = rxDoneCnt; f0 = feCnt; t0 = txDoneCnt;
            txq.delete();
            sendRx(vecs[i].data, vecs[i].stopBit, 1'b0);
            waitClk(900);
            check($sformatf("row%0d RxData", i), 32'(RxData), 32'(vecs[i].expRxData));
            check($sformatf("row%0d RxDone", i), 32'(rxDoneCnt - d0), 32'(vecs[i].expDone));
            check($sformatf("row%0d FrameErr", i), 32'(feCnt - f0), 32'(vecs[i].expFe));
            check($sformatf("row%0d TxDone", i), 32'(txDoneCnt - t0), 32'(vecs[i].expTx));
            check($sformatf("row%0d tx count", i), 32'(txq.size()), 32'(vecs[i].expTx));
            if (vecs[i].expTx == 1 && txq.size() > 0)
                check($sformatf("row%0d tx byte", i), 32'(txq[0]), 32'(vecs[i].data));
            check($sformatf("row%0d Level", i), 32'(Level), 32'd0);
        end

        // Glitch on Rx shorter than half a bit is rejected
        begin
            int lowBefore;
            EchoEn = 1'b1;
            d0 = rxDoneCnt; f0 = feCnt;
            lowBefore = txLowCnt;
            Rx = 1'b0;
            waitClk(20);
            Rx = 1'b1;
            waitClk(300);
            check("glitch RxDone", 32'(rxDoneCnt - d0), 32'd0);
            check("glitch FrameErr", 32'(feCnt - f0), 32'd0);
            check("glitch Tx idle", 32'(txLowCnt - lowBefore), 32'd0);
        end

        // Host burst 01..06: backpressure at Level 4, no overflow
        EchoEn = 1'b0;
        waitClk(4);
        txq.delete();
        sawBlock = 1'b0;
        for (int i = 1; i <= 6; i++) hostWrite(8'(i));
        check("burst saw TxReady low", 32'(sawBlock), 32'd1);
        check("burst level at block", 32'(levelAtBlock), 32'd4);
        check("burst Overflow", 32'(Overflow), 32'd0);
        for (int k = 0; k < 8000 && txq.size() < 6; k++) @(negedge Clk);
        check("burst tx count", 32'(txq.size()), 32'd6);
        for (int i = 0; i < 6 && i < txq.size(); i++)
            check($sformatf("burst byte%0d", i), 32'(txq[i]), 32'(i + 1));
        waitClk(100);
        check("burst Level end", 32'(Level), 32'd0);

        // Full FIFO + echo write -> dropped, sticky Overflow, OvfClr
        txq.delete();
        for (int i = 0; i < 5; i++) hostWrite(8'h11 + 8'(i));
        check("fill Level", 32'(Level), 32'd4);
        EchoEn = 1'b1;
        d0 = rxDoneCnt;
        sendRx(8'hE7, 1'b1, 1'b0);
        check("ovf RxDone", 32'(rxDoneCnt - d0), 32'd1);
        check("ovf RxData", 32'(RxData), 32'hE7);
        check("ovf set", 32'(Overflow), 32'd1);
        waitClk(50);
        check("ovf sticky", 32'(Overflow), 32'd1);
        @(negedge Clk);
        OvfClr = 1'b1;
        @(negedge Clk);
        OvfClr = 1'b0;
        check("ovf cleared", 32'(Overflow), 32'd0);
        for (int k = 0; k < 8000 && txq.size() < 5; k++) @(negedge Clk);
        waitClk(900);
        check("ovf tx count", 32'(txq.size()), 32'd5);
        for (int i = 0; i < 5 && i < txq.size(); i++)
            check($sformatf("ovf byte%0d", i), 32'(txq[i]), 32'h11 + 32'(i));

`ifdef PARITY_EN
        // Parity flipped -> ParityErr, no RxDone; then a good parity frame echoes
        begin
            int p0;
            txq.delete();
            p0 = peCnt; d0 = rxDoneCnt;
            sendRx(8'hA5, 1'b1, 1'b1);
            waitClk(900);
            check("par ParityErr", 32'(peCnt - p0), 32'd1);
            check("par RxDone", 32'(rxDoneCnt - d0), 32'd0);
            check("par RxData kept", 32'(RxData), 32'hE7);
            check("par no echo", 32'(txq.size()), 32'd0);
            sendRx(8'hA5, 1'b1, 1'b0);
            waitClk(900);
            check("par good RxData", 32'(RxData), 32'hA5);
            check("par good echo", 32'(txq.size()), 32'd1);
            if (txq.size() > 0) check("par echo byte", 32'(txq[0]), 32'hA5);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
